// File: rtl/pipeline_memory_control_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_memory_control_if
// Description : Bundle of signals between the EX/MEM latch, data cache and
//               pipeline latches on one side, and the memory-stage control
//               block on the other.
//               master : memory control block (drives requests, strobes, halt)
//               slave  : environment (latch contents, cache hits, read data)
//               Optional stall_cnt member exists only with MEMCTRL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_memory_control_if #(
    parameter int WORD_W      = 32,
    parameter int STALL_CNT_W = 32
);
    // Latched memory-stage request and control bits
    logic              dREN_mem;
    logic              dWEN_mem;
    logic              halt_mem;
    logic              brtaken_mem;
    // Fetch / cache handshake
    logic              ihit;
    logic              dhit;
    logic [WORD_W-1:0] dload;
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemload_mem;
    // Latch enables and flush strobes
    logic              en_fd;
    logic              en_de;
    logic              en_em;
    logic              en_mw;
    logic              flush_fd;
    logic              flush_de;
    logic              flush_em;
    logic              halt;
`ifdef MEMCTRL_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt;
`endif

    modport master (
        input  dREN_mem, dWEN_mem, halt_mem, brtaken_mem, ihit, dhit, dload,
`ifdef MEMCTRL_STATS_EN
        output stall_cnt,
`endif
        output dmemREN, dmemWEN, dmemload_mem,
        output en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halt
    );

    modport slave (
        output dREN_mem, dWEN_mem, halt_mem, brtaken_mem, ihit, dhit, dload,
`ifdef MEMCTRL_STATS_EN
        input  stall_cnt,
`endif
        input  dmemREN, dmemWEN, dmemload_mem,
        input  en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halt
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_memory_control.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_memory_control
// Description : Memory-stage controller at the consumer end of the EX/MEM
//               latch. Runs the data-cache request/acknowledge handshake,
//               holds load data while waiting for instruction fetch, drives
//               the latch enable/flush strobes and owns the sticky halt.
// Ports       : CLK  - clock, rising edge
//               nRST - synchronous active-low reset
//               bus  - pipeline_memory_control_if.master (requests, hits,
//                      load data, latch enables/flushes, halt, stall_cnt)
// Options     : MEMCTRL_STATS_EN - adds a saturating stall-cycle counter
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_memory_control #(
    parameter int WORD_W      = 32,
    parameter int STALL_CNT_W = 32
) (
    input  logic                        CLK,
    input  logic                        nRST,
    pipeline_memory_control_if.master   bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT_I = 2'd1,   // data access done, waiting for the fetch to finish
        HALTED = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] load_q;
    logic              mem_op;
    logic              mem_free;
    logic              adv;
    logic              do_flush;

    assign mem_op   = bus.dREN_mem | bus.dWEN_mem;
    // In WAIT_I the access already completed, so memory no longer holds us.
    assign mem_free = ~mem_op | bus.dhit | (state == WAIT_I);
    assign adv      = bus.ihit & mem_free & (state != HALTED);
    assign do_flush = bus.brtaken_mem & adv;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= RUN;
            load_q <= '0;
        end else begin
            state <= state_nxt;
            // Keep the returned word so it survives a fetch stall.
            if (bus.dhit && (state == RUN))
                load_q <= bus.dload;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.dmemWEN  = 1'b0;
        bus.dmemREN  = 1'b0;
        bus.en_fd    = 1'b0;
        bus.en_de    = 1'b0;
        bus.en_em    = 1'b0;
        bus.en_mw    = 1'b0;
        bus.flush_fd = 1'b0;
        bus.flush_de = 1'b0;
        bus.flush_em = 1'b0;

        case (state)
            RUN: begin
                if (mem_op && bus.dhit && !bus.ihit)
                    state_nxt = WAIT_I;
                else if (adv && bus.halt_mem)
                    state_nxt = HALTED;
            end
            WAIT_I: begin
                if (bus.ihit)
                    state_nxt = bus.halt_mem ? HALTED : RUN;
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase

        // Requests only issue from RUN; store wins when both bits are set.
        if (state == RUN) begin
            bus.dmemWEN = bus.dWEN_mem;
            bus.dmemREN = bus.dREN_mem & ~bus.dWEN_mem;
        end

        // The latches give enable priority over flush, so a flushed latch
        // must see its enable low. MEM/WB still advances on a flush.
        bus.en_mw    = adv;
        bus.en_fd    = adv & ~do_flush;
        bus.en_de    = adv & ~do_flush;
        bus.en_em    = adv & ~do_flush;
        bus.flush_fd = do_flush;
        bus.flush_de = do_flush;
        bus.flush_em = do_flush;
    end

    assign bus.dmemload_mem = (state == WAIT_I) ? load_q : bus.dload;
    assign bus.halt         = (state == HALTED);

`ifdef MEMCTRL_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Saturating count of non-halted cycles that did not advance.
    always_ff @(posedge CLK) begin
        if (!nRST)
            stall_q <= '0;
        else if ((state != HALTED) && !adv && (stall_q != '1))
            stall_q <= stall_q + STALL_CNT_W'(1);
    end

    assign bus.stall_cnt = stall_q;
`else
    if (STALL_CNT_W < 1) begin : g_bad_stall_cnt_w
        $error("STALL_CNT_W must be at least 1");
    end
`endif

endmodule
`default_nettype wire
